// File: rtl/pe_pkg.sv
// Shared PE datapath definitions: precision encodings, accumulator FSM
// state type and lane geometry helpers.
package pe_pkg;

   localparam int PRECISION_CONFIG_L = 2;

   localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_32B = 2'd0;
   localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_16B = 2'd1;
   localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_8B  = 2'd2;

   typedef enum logic [1:0] {
      ACC_IDLE = 2'd0,
      ACC_ACC  = 2'd1,
      ACC_HOLD = 2'd2
   } acc_state_e;

   // Any encoding other than 16B/8B behaves as 32B.
   function automatic logic [PRECISION_CONFIG_L-1:0] norm_mode(
      input logic [PRECISION_CONFIG_L-1:0] mode
   );
      case (mode)
         PRECISION_CONFIG_16B: return PRECISION_CONFIG_16B;
         PRECISION_CONFIG_8B:  return PRECISION_CONFIG_8B;
         default:              return PRECISION_CONFIG_32B;
      endcase
   endfunction

   function automatic int unsigned lane_count(
      input logic [PRECISION_CONFIG_L-1:0] mode
   );
      case (norm_mode(mode))
         PRECISION_CONFIG_16B: return 2;
         PRECISION_CONFIG_8B:  return 4;
         default:              return 1;
      endcase
   endfunction

   function automatic int unsigned lane_width(
      input logic [PRECISION_CONFIG_L-1:0] mode,
      input int unsigned                   acc_l
   );
      return acc_l / lane_count(mode);
   endfunction

endpackage

// File: rtl/decomposable_adder.sv
// 64b adder split into four 16b segments; the carry between segments is
// killed wherever a lane starts, so no carry ever crosses a lane boundary.
module decomposable_adder
   import pe_pkg::*;
#(
   parameter int ACC_L = 64
) (
   input  logic [PRECISION_CONFIG_L-1:0] mode,
   input  logic [ACC_L-1:0]              a,
   input  logic [ACC_L-1:0]              b,
   output logic [ACC_L-1:0]              sum,
   output logic [3:0]                    lane_co
);

   localparam int SEG_W = ACC_L / 4;

   logic [3:0] lane_start;
   logic [3:0] seg_co;

   // Segments that begin a lane start with carry-in zero.
   always_comb begin
      case (mode)
         PRECISION_CONFIG_16B: lane_start = 4'b0101;
         PRECISION_CONFIG_8B:  lane_start = 4'b1111;
         default:              lane_start = 4'b0001;
      endcase
   end

   // Ripple the four segments, gating each carry-in by lane_start.
   always_comb begin
      logic             cin;
      logic [SEG_W:0]   seg;
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      sum    = '0;
      seg_co = '0;
      cin    = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (lane_start[k]) cin = 1'b0;
         // NOTE: blocking '=' here is deliberate; cin must update before the next segment reads it.
         seg = {1'b0, a[k*SEG_W +: SEG_W]} + {1'b0, b[k*SEG_W +: SEG_W]}
             + {{SEG_W{1'b0}}, cin};
         sum[k*SEG_W +: SEG_W] = seg[SEG_W-1:0];
         seg_co[k]             = seg[SEG_W];
         cin                   = seg[SEG_W];
      end
   end

   // Report the carry out of each lane's top segment; unused lanes read 0.
   always_comb begin
      case (mode)
         PRECISION_CONFIG_16B: lane_co = {2'b00, seg_co[3], seg_co[1]};
         PRECISION_CONFIG_8B:  lane_co = seg_co;
         default:              lane_co = {3'b000, seg_co[3]};
      endcase
   end

endmodule

// File: rtl/mult_decomp_accumulator.sv
// Lane-decomposable accumulator: sums a group of product beats into
// 1x64b, 2x32b or 4x16b lanes and presents the result over valid/ready.
module mult_decomp_accumulator
   import pe_pkg::*;
#(
   parameter  int EACH_PART_LEN = 8,
   parameter  int N_PARTS       = 4,
   localparam int ACC_L         = 2 * EACH_PART_LEN * N_PARTS
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [PRECISION_CONFIG_L-1:0]      in_mode,
   input  logic [ACC_L-1:0]                   in_full,
   input  logic [1:0][ACC_L/2-1:0]            in_half,
   input  logic [3:0][ACC_L/4-1:0]            in_quarter,
   input  logic                               in_valid,
   input  logic                               in_last,
   output logic                               in_ready,
   output logic [ACC_L-1:0]                   out_acc,
   output logic [3:0]                         out_ovf,
   output logic [PRECISION_CONFIG_L-1:0]      out_mode,
   output logic                               out_valid,
   input  logic                               out_ready
);

   if (N_PARTS != 4) begin : g_bad_n_parts
      $error("mult_decomp_accumulator supports only N_PARTS == 4");
   end

   acc_state_e                    state_q, state_d;
   logic [ACC_L-1:0]              acc_q, acc_d;
   logic [3:0]                    ovf_q, ovf_d;
   logic [PRECISION_CONFIG_L-1:0] mode_q, mode_d;

   logic [PRECISION_CONFIG_L-1:0] sel_mode;
   logic [ACC_L-1:0]              beat;
   logic [ACC_L-1:0]              add_sum;
   logic [3:0]                    add_co;
   logic                          beat_fire;

   assign in_ready  = (state_q != ACC_HOLD);
   assign out_valid = (state_q == ACC_HOLD);
   assign out_acc   = acc_q;
   assign out_ovf   = ovf_q;
   assign out_mode  = mode_q;
   assign beat_fire = in_valid && in_ready;

   // Build the 64b operand; only the first beat of a group looks at in_mode.
   always_comb begin
      sel_mode = (state_q == ACC_IDLE) ? norm_mode(in_mode) : mode_q;
      case (sel_mode)
         PRECISION_CONFIG_16B: beat = in_half;
         PRECISION_CONFIG_8B:  beat = in_quarter;
         default:              beat = in_full;
      endcase
   end

   decomposable_adder #(.ACC_L(ACC_L)) u_adder (
      .mode    (mode_q),
      .a       (acc_q),
      .b       (beat),
      .sum     (add_sum),
      .lane_co (add_co)
   );

   // Group FSM: first beat loads, later beats add, HOLD presents the result.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      mode_d  = mode_q;
      case (state_q)
         ACC_IDLE: begin
            if (beat_fire) begin
               acc_d   = beat;
               ovf_d   = '0;
               mode_d  = sel_mode;
               state_d = in_last ? ACC_HOLD : ACC_ACC;
            end
         end
         ACC_ACC: begin
            if (beat_fire) begin
               acc_d = add_sum;
               ovf_d = ovf_q | add_co;
               if (in_last) state_d = ACC_HOLD;
            end
         end
         ACC_HOLD: begin
            if (out_ready) state_d = ACC_IDLE;
         end
         default: state_d = ACC_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACC_IDLE;
         // NOTE: the datapath registers are reset too, so out_acc/out_ovf read 0 right after reset.
         acc_q   <= '0;
         ovf_q   <= '0;
         mode_q  <= PRECISION_CONFIG_32B;
      end else begin
         // NOTE: non-blocking '<=' for all flops so every register samples pre-edge values.
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         mode_q  <= mode_d;
      end
   end

endmodule

// File: tb/tb_mult_decomp_accumulator.sv
// Scoreboard bench: the driver feeds beats into a lane-sum reference model
// that queues expected group results; a monitor pops on each output handshake.
module tb_mult_decomp_accumulator;
   import pe_pkg::*;

   localparam int ACC_L = 64;

   logic                          clk = 1'b0;
   logic                          rst_n;
   logic [PRECISION_CONFIG_L-1:0] in_mode;
   logic [ACC_L-1:0]              in_full;
   logic [1:0][ACC_L/2-1:0]       in_half;
   logic [3:0][ACC_L/4-1:0]       in_quarter;
   logic                          in_valid;
   logic                          in_last;
   logic                          in_ready;
   logic [ACC_L-1:0]              out_acc;
   logic [3:0]                    out_ovf;
   logic [PRECISION_CONFIG_L-1:0] out_mode;
   logic                          out_valid;
   logic                          out_ready;

   mult_decomp_accumulator #(.EACH_PART_LEN(8), .N_PARTS(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_mode    (in_mode),
      .in_full    (in_full),
      .in_half    (in_half),
      .in_quarter (in_quarter),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .out_acc    (out_acc),
      .out_ovf    (out_ovf),
      .out_mode   (out_mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] acc;
      logic [3:0]  ovf;
      logic [1:0]  mode;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   bit          rand_ready = 1'b0;

   // Reference model: unbounded per-lane sums of the current group.
   bit          grp_open = 1'b0;
   logic [1:0]  grp_mode;
   logic [79:0] lane_sum [4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int n_lanes(input logic [1:0] m);
      if (m == PRECISION_CONFIG_16B) return 2;
      if (m == PRECISION_CONFIG_8B)  return 4;
      return 1;
   endfunction

   task automatic model_accept(input logic [1:0] m, input logic [63:0] full,
                               input logic [1:0][31:0] half, input logic [3:0][15:0] quarter,
                               input bit last);
      int          n;
      int          w;
      logic [79:0] v;
      logic [79:0] mask;
      exp_t        e;
      if (!grp_open) begin
         grp_open = 1'b1;
         grp_mode = (m == PRECISION_CONFIG_16B || m == PRECISION_CONFIG_8B) ? m : PRECISION_CONFIG_32B;
         for (int k = 0; k < 4; k++) lane_sum[k] = '0;
      end
      n = n_lanes(grp_mode);
      w = 64 / n;
      for (int k = 0; k < n; k++) begin
         v = '0;
         if (n == 1)      v[63:0] = full;
         else if (n == 2) v[31:0] = half[k];
         else             v[15:0] = quarter[k];
         lane_sum[k] = lane_sum[k] + v;
      end
      if (last) begin
         mask  = (80'd1 << w) - 80'd1;
         e.acc  = '0;
         e.ovf  = '0;
         e.mode = grp_mode;
         for (int k = 0; k < n; k++) begin
            v = (lane_sum[k] & mask) << (k * w);
            e.acc  = e.acc | v[63:0];
            e.ovf[k] = ((lane_sum[k] >> w) != 80'd0);
         end
         exp_q.push_back(e);
         grp_open = 1'b0;
      end
   endtask

   task automatic model_reset();
      grp_open = 1'b0;
      exp_q.delete();
   endtask

   // Offer one beat and wait (bounded) until it is accepted.
   task automatic send_beat(input logic [1:0] m, input logic [63:0] full,
                            input logic [1:0][31:0] half, input logic [3:0][15:0] quarter,
                            input bit last);
      bit accepted = 1'b0;
      in_mode    = m;
      in_full    = full;
      in_half    = half;
      in_quarter = quarter;
      in_last    = last;
      in_valid   = 1'b1;
      for (int i = 0; i < 200 && !accepted; i++) begin
         @(negedge clk);
         if (in_ready) accepted = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!accepted) check("accept_timeout", 64'd0, 64'd1);
      else model_accept(m, full, half, quarter, last);
   endtask

   // Monitor: compare every completed output handshake against the scoreboard.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", out_acc, 64'hx);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_acc", out_acc, e.acc);
            check("out_ovf", {60'd0, out_ovf}, {60'd0, e.ovf});
            check("out_mode", {62'd0, out_mode}, {62'd0, e.mode});
         end
      end
   end

   // Random output backpressure during the random phase.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #500us;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] r64();
      logic [63:0] v;
      v = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) v = v | 64'hF000_F000_F000_F000;
      return v;
   endfunction

   initial begin
      logic [1:0][31:0] h;
      logic [3:0][15:0] q;
      logic [63:0]      qv;
      int               len;
      logic [1:0]       m;

      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      in_mode = PRECISION_CONFIG_32B; in_full = '0; in_half = '0; in_quarter = '0;
      #23;
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_mode", {62'd0, out_mode}, {62'd0, PRECISION_CONFIG_32B});
      check("rst_out_acc", out_acc, 64'd0);
      check("rst_out_ovf", {60'd0, out_ovf}, 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // 32B wrap: lane carry sets ovf[0], result zero.
      send_beat(PRECISION_CONFIG_32B, 64'hFFFF_FFFF_FFFF_FFFF, r64(), r64(), 1'b0);
      send_beat(PRECISION_CONFIG_32B, 64'h1, r64(), r64(), 1'b1);
      check("t32_valid", {63'd0, out_valid}, 64'd1);
      check("t32_acc", out_acc, 64'd0);
      check("t32_ovf", {60'd0, out_ovf}, 64'd1);

      // 16B: lane 0 wraps, lane 1 unaffected.
      h[1] = 32'h1; h[0] = 32'hFFFF_FFFF;
      send_beat(PRECISION_CONFIG_16B, r64(), h, r64(), 1'b0);
      h[1] = 32'h2; h[0] = 32'h1;
      send_beat(PRECISION_CONFIG_16B, r64(), h, r64(), 1'b1);
      check("t16_acc", out_acc, 64'h0000_0003_0000_0000);
      check("t16_ovf", {60'd0, out_ovf}, 64'd1);

      // 8B: three identical beats.
      q[3] = 16'h8000; q[2] = 16'h0001; q[1] = 16'hFFFF; q[0] = 16'h0010;
      send_beat(PRECISION_CONFIG_8B, r64(), r64(), q, 1'b0);
      send_beat(PRECISION_CONFIG_8B, r64(), r64(), q, 1'b0);
      send_beat(PRECISION_CONFIG_8B, r64(), r64(), q, 1'b1);
      check("t8_acc", out_acc, 64'h8000_0003_FFFD_0030);
      check("t8_ovf", {60'd0, out_ovf}, 64'b1010);

      // Single-beat 8B group held under backpressure while a 32B beat waits.
      @(posedge clk); #1;
      out_ready = 1'b0;
      q[3] = 16'hA5A5; q[2] = 16'h0102; q[1] = 16'hFFFF; q[0] = 16'h7E7E;
      qv = q;
      send_beat(PRECISION_CONFIG_8B, r64(), r64(), q, 1'b1);
      check("single_acc", out_acc, qv);
      check("single_ovf", {60'd0, out_ovf}, 64'd0);
      in_mode = PRECISION_CONFIG_32B; in_full = 64'hDEAD_BEEF_0123_4567;
      in_last = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready", {63'd0, in_ready}, 64'd0);
         check("bp_out_valid", {63'd0, out_valid}, 64'd1);
         check("bp_out_acc", out_acc, qv);
         check("bp_out_mode", {62'd0, out_mode}, {62'd0, PRECISION_CONFIG_8B});
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_ready_back", {63'd0, in_ready}, 64'd1);
      check("bp_valid_drop", {63'd0, out_valid}, 64'd0);
      send_beat(PRECISION_CONFIG_32B, 64'hDEAD_BEEF_0123_4567, r64(), r64(), 1'b1);
      check("bp_fresh_acc", out_acc, 64'hDEAD_BEEF_0123_4567);
      check("bp_fresh_mode", {62'd0, out_mode}, {62'd0, PRECISION_CONFIG_32B});
      @(posedge clk); #1;

      // Reset mid-group after two beats discards the partial sum.
      send_beat(PRECISION_CONFIG_16B, r64(), r64(), r64(), 1'b0);
      send_beat(PRECISION_CONFIG_16B, r64(), r64(), r64(), 1'b0);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      check("mid_rst_ready", {63'd0, in_ready}, 64'd1);
      check("mid_rst_acc", out_acc, 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      q[3] = 16'h1111; q[2] = 16'h2222; q[1] = 16'h3333; q[0] = 16'h4444;
      send_beat(PRECISION_CONFIG_8B, r64(), r64(), q, 1'b1);
      check("post_rst_acc", out_acc, 64'h1111_2222_3333_4444);
      check("post_rst_ovf", {60'd0, out_ovf}, 64'd0);

      // Reset while presenting a result drops out_valid at once.
      @(posedge clk); #1;
      out_ready = 1'b0;
      send_beat(PRECISION_CONFIG_32B, r64(), r64(), r64(), 1'b1);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("hold_rst_valid", {63'd0, out_valid}, 64'd0);
      check("hold_rst_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;

      // Random groups; in_mode on non-first beats is random and must be ignored.
      rand_ready = 1'b1;
      for (int g = 0; g < 60; g++) begin
         len = $urandom_range(1, 5);
         m   = 2'($urandom_range(0, 3));
         for (int b = 0; b < len; b++) begin
            send_beat((b == 0) ? m : 2'($urandom_range(0, 3)), r64(), r64(), r64(), (b == len - 1));
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk); #1;
            end
         end
      end
      rand_ready = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_decomp_accumulator.md
# mult_decomp_accumulator

Lane-decomposable accumulator that sits directly downstream of the decomposable multiplier in the PE datapath. It consumes one product beat per cycle in 32B, 16B or 8B precision mode and sums a group of beats into 1×64b, 2×32b or 4×16b lanes, with no carry crossing lane boundaries. When the group completes, it presents the packed result with per-lane sticky overflow flags over a valid/ready handshake.

## Interface
Parameters:
- EACH_PART_LEN, 8, width of one multiplier sub-part.
- N_PARTS, 4, number of sub-parts. Only 4 is supported; elaboration asserts this.
- ACC_L, derived as 2*EACH_PART_LEN*N_PARTS (64), accumulator width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_mode  in  PRECISION_CONFIG_L  precision of the beat (pe_pkg::PRECISION_CONFIG_32B/16B/8B)
- in_full  in  ACC_L  64b product (used in 32B mode)
- in_half  in  [1:0][ACC_L/2]  two 32b products (used in 16B mode)
- in_quarter  in  [3:0][ACC_L/4]  four 16b products (used in 8B mode)
- in_valid  in  1  beat valid
- in_last  in  1  beat closes the group
- in_ready  out  1  beat accepted when in_valid && in_ready
- out_acc  out  ACC_L  packed lanes; lane k sits at [k*lane_w +: lane_w]
- out_ovf  out  4  sticky unsigned carry-out per lane; bits above the lane count read 0
- out_mode  out  PRECISION_CONFIG_L  mode of the presented group
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result

## Operation
- States: IDLE, ACC, HOLD.
- Reset (async) sets:
  - state=IDLE, acc=0, ovf=0;
  - out_valid=0, in_ready=1, out_mode=PRECISION_CONFIG_32B.
- in_ready = (state != HOLD).
- IDLE, beat accepted:
  - acc <= beat and ovf <= 0; there is no add.
  - grp_mode <= in_mode.
  - Next state is HOLD if in_last, else ACC.
- ACC, beat accepted:
  - acc <= acc + beat, lanewise, using grp_mode.
  - ovf |= lane carry-outs.
  - in_mode is ignored inside a group.
  - If in_last, next state is HOLD.
- HOLD:
  - out_valid=1; out_acc, out_ovf and out_mode are stable.
  - On out_ready, the block goes to IDLE. acc and ovf are not cleared until the next first beat.
- Lane mapping:
  - 32B: 1 lane, in_full.
  - 16B: lane k = in_half[k].
  - 8B: lane k = in_quarter[k].
  - Unsigned, modulo lane width. A carry out of a lane's MSB sets ovf[k] and never propagates into lane k+1.
- An unrecognised mode encoding is treated as 32B.
- out_* values outside HOLD are don't-care, except out_valid=0.

## Timing
- Single register stage: the last beat accepted at edge t gives out_valid=1 after edge t.
- Throughput: 1 beat per cycle within a group.
- One bubble per group: a beat offered in HOLD waits, and in_ready returns to 1 the cycle after the out_ready handshake.
- Simultaneous in_valid and out_valid/out_ready in HOLD: only the output handshake completes. The input beat is held by the producer.
- An asynchronous reset mid-group discards partial sums. Outputs reach reset values immediately, and the first beat after reset release starts a new group.

## Structure
- pe_pkg holds the PRECISION_CONFIG_* constants (already shared) and a new typedef for the accumulator state enum. The lane-count and lane-width helper functions also go in pe_pkg.
- Sub-module decomposable_adder, combinational:
  - 64b a+b, with carry killed at the 16b boundaries per mode.
  - Outputs the sum plus 4 lane carry-outs (16b boundaries 15/31/47/63, grouped per mode).
- The top level contains the FSM, the beat-mux that builds the 64b operand from in_full/in_half/in_quarter, and the registers.

## Test plan
- 32B, two beats: in_full=64'hFFFF_FFFF_FFFF_FFFF, then 64'h1 with last -> out_acc=0, out_ovf=4'b0001, out_valid one cycle after the last beat.
- 16B, two beats:
  - Beat 1: half={32'h1, 32'hFFFF_FFFF}.
  - Beat 2: half={32'h2, 32'h1} with last.
  - Response: out_acc={32'h3, 32'h0}, out_ovf=4'b0001. No carry leaks into lane 1.
- 8B, three beats, each quarter={16'h8000, 16'h0001, 16'hFFFF, 16'h0010}, last on the third:
  - out_acc={16'h8000, 16'h0003, 16'hFFFD, 16'h0030}.
  - out_ovf=4'b1010.
- Single-beat group (in_last on the first beat) in 8B mode: out_acc equals the beat, out_ovf=0. in_mode changed to 32B on that cycle's next beat does not alter out_mode.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 throughout and out_acc stable. After out_ready=1, the held beat is accepted the following cycle as a fresh group.
- Assert rst_n low mid-group after 2 beats -> out_valid=0 and in_ready=1 immediately. A following 1-beat group returns exactly that beat.
